// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle RV32I main control FSM.
// Drives datapath selects/enables, counts retired instructions and flags bad opcodes.
module mc_main_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_src,
    output logic        reg_write,
    output logic        illegal,
    output logic [31:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t r_state, w_next;
    logic   r_dummy_unused;
    logic   w_pc_update, w_branch, w_ir_write, w_mem_write, w_reg_write, w_op_legal;

    assign r_dummy_unused = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else r_state <= w_next;
    end

    // Only instructions that reach their final step retire; illegal Decode->Fetch does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instret <= 32'd0;
        else if (r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ}) instret <= instret + 32'd1;
    end

    assign w_op_legal = op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                               (op == OP_R)   ? S_EXECR :
                               (op == OP_I)   ? S_EXECI :
                               (op == OP_JAL) ? S_JAL   :
                               (op == OP_BEQ) ? S_BEQ   : S_FETCH;
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; w_pc_update = 1'b1;
            end
            S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = 2'b01; w_reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; w_mem_write = 1'b1; end
            S_EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
            S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    w_reg_write = 1'b1;
            S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; w_pc_update = 1'b1; end
            S_BEQ:      begin alu_src_a = 2'b10; alu_op = 2'b01; w_branch = 1'b1; end
            default:    ;
        endcase
    end

    // Reset holds state at Fetch asynchronously, so only the enables need masking.
    assign pc_write  = ~reset & (w_pc_update | (w_branch & zero));
    assign ir_write  = ~reset & w_ir_write;
    assign mem_write = ~reset & w_mem_write;
    assign reg_write = ~reset & w_reg_write;
    assign illegal   = ~reset & (r_state == S_DECODE) & ~w_op_legal;

    assign imm_src = (op == OP_SW)  ? 2'b01 :
                     (op == OP_BEQ) ? 2'b10 :
                     (op == OP_JAL) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed per-cycle vectors with a queue-based scoreboard for mc_main_fsm.
module tb_mc_main_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = 7'b0000011;
    logic        zero = 1'b0;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [31:0] instret;

    mc_main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b1111111;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal}
    localparam logic [15:0] RST    = 16'b0_0_0_0_10_00_10_00_00_0_0;
    localparam logic [15:0] FETCH  = 16'b1_0_0_1_10_00_10_00_00_0_0;
    localparam logic [15:0] DECODE = 16'b0_0_0_0_00_01_01_00_00_0_0;
    localparam logic [15:0] MEMADR = 16'b0_0_0_0_00_10_01_00_00_0_0;
    localparam logic [15:0] MEMRD  = 16'b0_1_0_0_00_00_00_00_00_0_0;
    localparam logic [15:0] MEMWB  = 16'b0_0_0_0_01_00_00_00_00_1_0;
    localparam logic [15:0] MEMWR  = 16'b0_1_1_0_00_00_00_00_00_0_0;
    localparam logic [15:0] EXR    = 16'b0_0_0_0_00_10_00_10_00_0_0;
    localparam logic [15:0] EXI    = 16'b0_0_0_0_00_10_01_10_00_0_0;
    localparam logic [15:0] ALUWB  = 16'b0_0_0_0_00_00_00_00_00_1_0;
    localparam logic [15:0] JAL    = 16'b1_0_0_0_00_01_10_00_00_0_0;
    localparam logic [15:0] BEQ    = 16'b0_0_0_0_00_10_00_01_00_0_0;
    localparam logic [15:0] I_SW = 16'h0004, I_BQ = 16'h0008, I_JL = 16'h000C;
    localparam logic [15:0] PCW = 16'h8000, ILL = 16'h0001;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic [15:0] w;
        logic [31:0] ir;
    } vec_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] w;
        logic [31:0] ir;
    } exp_t;

    localparam int N = 35;
    vec_t vecs [N];
    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    wire [15:0] w_act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                         alu_src_b, alu_op, imm_src, reg_write, illegal};

    initial begin
        vecs = '{
            '{1'b1, LW, 1'b0, RST, 32'd0},
            '{1'b0, LW, 1'b0, FETCH, 32'd0},
            '{1'b0, LW, 1'b0, DECODE, 32'd0},
            '{1'b0, LW, 1'b0, MEMADR, 32'd0},
            '{1'b0, LW, 1'b0, MEMRD, 32'd0},
            '{1'b0, LW, 1'b0, MEMWB, 32'd0},
            '{1'b0, LW, 1'b0, FETCH, 32'd1},
            '{1'b0, LW, 1'b0, DECODE, 32'd1},
            '{1'b0, LW, 1'b0, MEMADR, 32'd1},
            '{1'b1, LW, 1'b0, RST, 32'd0},
            '{1'b0, SW, 1'b0, FETCH | I_SW, 32'd0},
            '{1'b0, SW, 1'b0, DECODE | I_SW, 32'd0},
            '{1'b0, SW, 1'b0, MEMADR | I_SW, 32'd0},
            '{1'b0, SW, 1'b0, MEMWR | I_SW, 32'd0},
            '{1'b0, BQ, 1'b1, FETCH | I_BQ, 32'd1},
            '{1'b0, BQ, 1'b1, DECODE | I_BQ, 32'd1},
            '{1'b0, BQ, 1'b1, BEQ | I_BQ | PCW, 32'd1},
            '{1'b0, BQ, 1'b0, FETCH | I_BQ, 32'd2},
            '{1'b0, BQ, 1'b0, DECODE | I_BQ, 32'd2},
            '{1'b0, BQ, 1'b0, BEQ | I_BQ, 32'd2},
            '{1'b0, RT, 1'b0, FETCH, 32'd3},
            '{1'b0, RT, 1'b1, DECODE, 32'd3},
            '{1'b0, RT, 1'b1, EXR, 32'd3},
            '{1'b0, RT, 1'b0, ALUWB, 32'd3},
            '{1'b0, IT, 1'b0, FETCH, 32'd4},
            '{1'b0, IT, 1'b0, DECODE, 32'd4},
            '{1'b0, IT, 1'b0, EXI, 32'd4},
            '{1'b0, IT, 1'b0, ALUWB, 32'd4},
            '{1'b0, JL, 1'b0, FETCH | I_JL, 32'd5},
            '{1'b0, JL, 1'b0, DECODE | I_JL, 32'd5},
            '{1'b0, JL, 1'b0, JAL | I_JL, 32'd5},
            '{1'b0, JL, 1'b0, ALUWB | I_JL, 32'd5},
            '{1'b0, BAD, 1'b0, FETCH, 32'd6},
            '{1'b0, BAD, 1'b0, DECODE | ILL, 32'd6},
            '{1'b0, BAD, 1'b0, FETCH, 32'd6}
        };
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst;
            op    = vecs[i].op;
            zero  = vecs[i].z;
            q.push_back('{i[7:0], vecs[i].w, vecs[i].ir});
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_tests += 2;
                if (w_act !== e.w) begin
                    n_fail++;
                    $display("FAIL row%0d ctrl: got %b expected %b", e.idx, w_act, e.w);
                end
                if (instret !== e.ir) begin
                    n_fail++;
                    $display("FAIL row%0d instret: got %0d expected %0d", e.idx, instret, e.ir);
                end
            end
        end
    end
endmodule
